imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 39 +++
 rtl/imem_loader.sv | 136 +++++++++++++
 tb/tb_imem_loader.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared pipeline package: instruction-code constants plus the program loader's
// state encoding and frame-field widths.
`default_nettype none

package imem_loader_pkg;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
  localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  // Frame length field is a 16-bit little-endian byte count.
  localparam int LEN_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } load_state_t;

  function automatic logic is_stream_state(input load_state_t s);
    return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

`default_nettype wire

// File: rtl/imem_loader.sv
// Byte-stream program loader: parses LEN/payload/CSUM frames, writes the payload
// into byte-wide instruction memory and holds the CPU until a load succeeds.
`default_nettype none

module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 10   // must stay below LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  // 2^ADDR_W expressed at length-field width plus one bit.
  localparam logic [LEN_W:0] MAX_LEN = {{(LEN_W-ADDR_W){1'b0}}, 1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  load_state_t      state;
  load_state_t      state_nx;
  logic [7:0]       len_lo;
  logic [LEN_W-1:0] len;
  logic [ADDR_W:0]  cnt;
  logic [7:0]       xsum;

  logic             xfer;
  logic [LEN_W-1:0] len_rx;
  logic             len_over;
  logic             len_zero;
  logic [ADDR_W:0]  cnt_inc;
  logic             last_byte;
  logic             csum_ok;

  assign in_ready  = is_stream_state(state);
  assign xfer      = in_valid & in_ready;
  assign len_rx    = {in_data, len_lo};
  assign len_over  = {1'b0, len_rx} > MAX_LEN;
  assign len_zero  = (len_rx == '0);
  assign cnt_inc   = cnt + CNT_ONE;
  assign last_byte = ({{(LEN_W-ADDR_W){1'b0}}, cnt_inc} == {1'b0, len});
  assign csum_ok   = (in_data == xsum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: if (start) state_nx = ST_LEN_LO;
      ST_LEN_LO: if (xfer) state_nx = ST_LEN_HI;
      ST_LEN_HI: begin
        if (xfer) begin
          if (len_over)      state_nx = ST_ERR;
          else if (len_zero) state_nx = ST_CSUM;
          else               state_nx = ST_DATA;
        end
      end
      ST_DATA: if (xfer && last_byte) state_nx = ST_CSUM;
      ST_CSUM: if (xfer) state_nx = csum_ok ? ST_DONE : ST_ERR;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Write strobe is a registered single-cycle pulse following each payload transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_lo    <= '0;
      len       <= '0;
      cnt       <= '0;
      xsum      <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      cpu_hold  <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            load_done <= 1'b0;
            load_err  <= 1'b0;
            cpu_hold  <= 1'b1;
          end
        end
        ST_LEN_LO: if (xfer) len_lo <= in_data;
        ST_LEN_HI: begin
          if (xfer) begin
            len  <= len_rx;
            cnt  <= '0;
            xsum <= '0;
            if (len_over) load_err <= 1'b1;
          end
        end
        ST_DATA: begin
          if (xfer) begin
            wr_en   <= 1'b1;
            wr_addr <= cnt[ADDR_W-1:0];
            wr_data <= in_data;
            cnt     <= cnt_inc;
            xsum    <= xsum ^ in_data;
          end
        end
        ST_CSUM: begin
          if (xfer) begin
            if (csum_ok) begin
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              load_err  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader with a frame-position reference model.
`default_nettype none

module tb_imem_loader;

  localparam int ADDR_W = 10;
  localparam int CAP    = 1 << ADDR_W;

  typedef logic [7:0] byteq_t[$];

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference model: tracks position within the frame rather than any state encoding.
  bit         m_busy, m_hold, m_done, m_err, m_wr;
  int         m_pos, m_n, m_addr;
  logic [7:0] m_lo, m_xor, m_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_hold <= 1; m_done <= 0; m_err <= 0; m_wr <= 0;
      m_pos <= 0; m_n <= 0; m_addr <= 0; m_lo <= 0; m_xor <= 0; m_data <= 0;
    end else begin
      m_wr <= 0;
      if (!m_busy) begin
        if (start) begin
          m_busy <= 1; m_pos <= 0; m_done <= 0; m_err <= 0; m_hold <= 1;
        end
      end else if (in_valid) begin
        if (m_pos == 0) begin
          m_lo <= in_data; m_pos <= 1;
        end else if (m_pos == 1) begin
          if (int'({in_data, m_lo}) > CAP) begin
            m_busy <= 0; m_err <= 1;
          end else begin
            m_n <= int'({in_data, m_lo}); m_xor <= 0; m_pos <= 2;
          end
        end else if (m_pos - 2 < m_n) begin
          m_wr <= 1; m_addr <= m_pos - 2; m_data <= in_data;
          m_xor <= m_xor ^ in_data; m_pos <= m_pos + 1;
        end else begin
          m_busy <= 0;
          if (in_data == m_xor) begin
            m_done <= 1; m_hold <= 0;
          end else begin
            m_err <= 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", 32'(in_ready), 32'(m_busy));
      check("wr_en", 32'(wr_en), 32'(m_wr));
      check("cpu_hold", 32'(cpu_hold), 32'(m_hold));
      check("load_done", 32'(load_done), 32'(m_done));
      check("load_err", 32'(load_err), 32'(m_err));
      if (m_wr) begin
        check("wr_addr", 32'(wr_addr), 32'(m_addr));
        check("wr_data", 32'(wr_data), 32'(m_data));
      end
    end
  end

  int         cap_addr[$];
  logic [7:0] cap_data[$];
  int         cap_cyc[$];

  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      cap_addr.push_back(int'(wr_addr));
      cap_data.push_back(wr_data);
      cap_cyc.push_back(cycle);
    end
  end

  function automatic byteq_t mk_frame(input int n, input bit good);
    byteq_t     f;
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    f.push_back(n[7:0]);
    f.push_back(n[15:8]);
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      f.push_back(b);
      x = x ^ b;
    end
    f.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
    return f;
  endfunction

  // Caller is at a negedge; returns at a negedge.
  task automatic send_frame(input byteq_t fr, input int max_bytes, input bit rnd_valid,
                            input int start_at);
    int idx;
    int budget;
    int limit;
    bit accepted;
    bit pulsed;
    idx = 0;
    pulsed = 0;
    limit = (max_bytes < fr.size()) ? max_bytes : fr.size();
    budget = 8 * fr.size() + 50;
    cap_addr.delete(); cap_data.delete(); cap_cyc.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (idx < limit && budget > 0) begin
      in_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = in_valid ? fr[idx] : 8'($urandom);
      if (idx == start_at && !pulsed) begin
        start = 1'b1;
        pulsed = 1;
      end else begin
        start = 1'b0;
      end
      accepted = in_valid && in_ready;
      @(negedge clk);
      if (accepted) idx++;
      budget--;
    end
    in_valid = 1'b0;
    start = 1'b0;
    check("bytes_accepted", idx, limit);
  endtask

  task automatic verify(input byteq_t fr, input bit b2b);
    int         n;
    logic [7:0] x;
    bit         ok;
    n = int'({fr[1], fr[0]});
    if (n > CAP) begin
      check("ovl_writes", cap_addr.size(), 0);
      check("ovl_err", 32'(load_err), 1);
      check("ovl_done", 32'(load_done), 0);
      check("ovl_hold", 32'(cpu_hold), 1);
      return;
    end
    x = 8'h00;
    for (int i = 0; i < n; i++) x = x ^ fr[2 + i];
    ok = (fr[2 + n] == x);
    check("wr_count", cap_addr.size(), n);
    for (int i = 0; i < n && i < cap_addr.size(); i++) begin
      check("seq_addr", cap_addr[i], i);
      check("seq_data", 32'(cap_data[i]), 32'(fr[2 + i]));
      if (b2b) check("seq_consec", cap_cyc[i] - cap_cyc[0], i);
    end
    check("final_done", 32'(load_done), 32'(ok));
    check("final_err", 32'(load_err), 32'(!ok));
    check("final_hold", 32'(cpu_hold), 32'(!ok));
  endtask

  task automatic reset_checks();
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    check("rst_cpu_hold", 32'(cpu_hold), 1);
    check("rst_load_done", 32'(load_done), 0);
    check("rst_load_err", 32'(load_err), 0);
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1 reset_checks();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  byteq_t f033;
  byteq_t fbad;
  byteq_t fovl;
  byteq_t fzero;
  byteq_t fr;

  initial begin
    f033  = '{8'h03, 8'h00, 8'h30, 8'hF3, 8'h0A, 8'hC9};
    fbad  = '{8'h03, 8'h00, 8'h30, 8'hF3, 8'h0A, 8'h00};
    fovl  = '{8'h01, 8'h04};
    fzero = '{8'h00, 8'h00, 8'h00};

    repeat (3) @(negedge clk);
    #1 reset_checks();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Good frame, back-to-back, with literal expectations.
    send_frame(f033, 99, 0, -1);
    settle();
    verify(f033, 1);
    check("lit_count", cap_addr.size(), 3);
    if (cap_addr.size() == 3) begin
      check("lit_a0", cap_addr[0], 0); check("lit_d0", 32'(cap_data[0]), 32'h30);
      check("lit_a1", cap_addr[1], 1); check("lit_d1", 32'(cap_data[1]), 32'hF3);
      check("lit_a2", cap_addr[2], 2); check("lit_d2", 32'(cap_data[2]), 32'h0A);
      check("lit_consec", cap_cyc[2] - cap_cyc[0], 2);
    end
    check("lit_done", 32'(load_done), 1);
    check("lit_hold", 32'(cpu_hold), 0);

    // Bad checksum.
    send_frame(fbad, 99, 0, -1);
    settle();
    verify(fbad, 1);
    check("bad_writes", cap_addr.size(), 3);
    check("bad_err", 32'(load_err), 1);
    check("bad_done", 32'(load_done), 0);
    check("bad_hold", 32'(cpu_hold), 1);

    // Overlength N = 2^ADDR_W + 1.
    send_frame(fovl, 99, 0, -1);
    settle();
    verify(fovl, 0);
    check("ovl_lit_err", 32'(load_err), 1);

    // Empty frame.
    send_frame(fzero, 99, 0, -1);
    settle();
    verify(fzero, 0);
    check("zero_done", 32'(load_done), 1);

    // Throttled source on the good frame.
    send_frame(f033, 99, 1, -1);
    settle();
    verify(f033, 0);

    // Reset after the first payload byte, then a clean reload.
    send_frame(f033, 3, 0, -1);
    pulse_reset();
    settle();
    check("midrst_writes", cap_addr.size(), 1);
    check("midrst_hold", 32'(cpu_hold), 1);
    check("midrst_ready", 32'(in_ready), 0);
    send_frame(f033, 99, 0, -1);
    settle();
    verify(f033, 1);

    // start pulsed during the payload is ignored.
    send_frame(f033, 99, 0, 3);
    settle();
    verify(f033, 1);

    // Random frames: mixed lengths, checksums and throttling.
    for (int t = 0; t < 10; t++) begin
      fr = mk_frame($urandom_range(1, 40), 1'($urandom_range(0, 1)));
      send_frame(fr, 999, 1'($urandom_range(0, 1)), -1);
      settle();
      verify(fr, 0);
    end

    // Full-capacity frame: addresses run up to 2^ADDR_W-1 without wrapping.
    fr = mk_frame(CAP, 1);
    send_frame(fr, 99999, 0, -1);
    settle();
    verify(fr, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule

`default_nettype wire
